// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: FSM state
// encoding, counter sizing helpers and the full-adder cell.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int unsigned n);
    int          r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Digit counter width: never narrower than one bit.
  function automatic int ctr_width(input int unsigned cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    logic s;
    logic co;
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
    return {co, s};
  endfunction

endpackage

// File: rtl/digit_serial_addsub_addn_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells. Also
// exposes the carry into its MSB so the top level can form signed overflow.
module addn_slice
  import digit_serial_addsub_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  // Ripple the carry through DIGIT full-adder cells.
  always_comb begin
    logic [1:0] fa;
    c    = '0;
    s    = '0;
    fa   = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      fa     = full_add(a[i], b[i], c[i]);
      s[i]   = fa[0];
      c[i+1] = fa[1];
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per
// clock with a start/busy/done handshake and held result and flags.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CYCLES = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW     = ctr_width(CYCLES);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("digit_serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cm;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] acc_next;

  addn_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a    (opa_q[DIGIT-1:0]),
    .b    (opb_q[DIGIT-1:0]),
    .cin  (cy_q),
    .s    (dig_s),
    .cout (dig_co),
    .cmsb (dig_cm)
  );

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(CYCLES - 1));

  // Result digits enter from the MSB end; after CYCLES shifts the first digit
  // has reached bit 0. Shifting by WIDTH (DIGIT == WIDTH) yields zero.
  always_comb begin
    dig_ext              = '0;
    dig_ext[DIGIT-1:0]   = dig_s;
    acc_next             = (acc_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture on accept, one digit per RUN cycle.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      opa_d = A;
      opb_d = sub ? ~B : B;
      cy_d  = CarryIn ^ sub;
      cnt_d = '0;
      acc_d = '0;
    end else if (state_q == RUN) begin
      opa_d = opa_q >> DIGIT;
      opb_d = opb_q >> DIGIT;
      acc_d = acc_next;
      cy_d  = dig_co;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d   = acc_next;
        carry_d = dig_co;
        ovf_d   = dig_co ^ dig_cm;
        zero_d  = (acc_next == '0);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
